// File: rtl/fp_pkg.sv
// Shared definitions for the 16-bit scaled fixed-point word {scale[2:0], mantissa[12:0]}
// and the summation state machine.
package fp_pkg;
    localparam int FP_W      = 16;
    localparam int SCALE_W   = 3;
    localparam int MANT_W    = 13;
    localparam int MAX_SCALE = 7;
    localparam int MANT_MAX  = 4095;
    localparam int MANT_MIN  = -4096;

    typedef enum logic [1:0] {
        ACCUM,
        NORM,
        OUT
    } state_t;
endpackage

// File: rtl/fp_unpack.sv
// Splits a scaled fixed-point word into its scale and a sign-extended addend
// aligned to the fixed internal scale (MAX_SCALE fractional bits).
module fp_unpack
    import fp_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic [FP_W-1:0]           word,
    output logic [SCALE_W-1:0]        scale,
    output logic signed [ACC_W-1:0]   addend
);
    logic [MANT_W-1:0]  mant;
    logic [SCALE_W-1:0] shamt;

    assign scale  = word[FP_W-1 -: SCALE_W];
    assign mant   = word[MANT_W-1:0];
    assign shamt  = SCALE_W'(MAX_SCALE) - scale;
    assign addend = $signed({{(ACC_W-MANT_W){mant[MANT_W-1]}}, mant}) <<< shamt;
endmodule

// File: rtl/fp_accumulator.sv
// Sums a stream of scaled fixed-point products and renormalises the total to 16 bits.
// Build option: NORM_ROUND_EN selects round-half-up instead of truncation in NORM.
module fp_accumulator
    import fp_pkg::*;
#(
    parameter int ACC_W     = 24,
    parameter int MAX_TERMS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] out_data,
    output logic            overflow,
    output logic            busy
);
    localparam int CNT_W = $clog2(MAX_TERMS);

    state_t                   state, state_next;
    logic signed [ACC_W-1:0]  acc, pend_add, beat_add, acc_sum;
    logic                     pend_vld, ovf, add_ovf;
    logic [CNT_W-1:0]         cnt;
    logic [SCALE_W-1:0]       beat_scale, trial_t, shamt;
    logic                     accept, beat_end, trial_fit;
    logic signed [ACC_W:0]    acc_ext, acc_rnd, trial;

    fp_unpack #(.ACC_W(ACC_W)) u_unpack (
        .word   (in_data),
        .scale  (beat_scale),
        .addend (beat_add)
    );

    // Accepted beats are staged one cycle before the add to keep unpack and add off one path.
    assign acc_sum  = acc + pend_add;
    assign add_ovf  = (acc[ACC_W-1] == pend_add[ACC_W-1]) && (acc_sum[ACC_W-1] != acc[ACC_W-1]);
    assign accept   = (state == ACCUM) && in_valid && !clear;
    assign beat_end = in_last || (cnt == CNT_W'(MAX_TERMS - 1));

    assign shamt   = SCALE_W'(MAX_SCALE) - trial_t;
    assign acc_ext = {acc[ACC_W-1], acc};
`ifdef NORM_ROUND_EN
    assign acc_rnd = (shamt == '0) ? acc_ext
                                   : acc_ext + $signed((ACC_W+1)'(1) << (shamt - SCALE_W'(1)));
`else
    assign acc_rnd = acc_ext;
`endif
    assign trial     = acc_rnd >>> shamt;
    assign trial_fit = (trial >= (ACC_W+1)'(MANT_MIN)) && (trial <= (ACC_W+1)'(MANT_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACCUM;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = !clear && !rst;
                if (accept && beat_end) state_next = NORM;
            end
            NORM: begin
                busy = 1'b1;
                if (!pend_vld && (trial_fit || trial_t == '0)) state_next = OUT;
            end
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = ACCUM;
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            ovf      <= 1'b0;
            cnt      <= '0;
            pend_vld <= 1'b0;
            pend_add <= '0;
            trial_t  <= '0;
            out_data <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (clear) begin
                        acc      <= '0;
                        ovf      <= 1'b0;
                        cnt      <= '0;
                        pend_vld <= 1'b0;
                    end else begin
                        if (pend_vld) begin
                            acc <= acc_sum;
                            ovf <= ovf | add_ovf;
                        end
                        pend_vld <= accept;
                        pend_add <= beat_add;
                        if (accept) begin
                            cnt     <= cnt + CNT_W'(1);
                            trial_t <= SCALE_W'(MAX_SCALE);
                        end
                    end
                end
                NORM: begin
                    // The final staged beat lands before the first trial.
                    if (pend_vld) begin
                        acc      <= acc_sum;
                        ovf      <= ovf | add_ovf;
                        pend_vld <= 1'b0;
                    end else if (trial_fit) begin
                        out_data <= {trial_t, trial[MANT_W-1:0]};
                        overflow <= ovf;
                    end else if (trial_t != '0) begin
                        trial_t <= trial_t - SCALE_W'(1);
                    end else begin
                        out_data <= {trial_t, acc[ACC_W-1] ? MANT_W'(MANT_MIN) : MANT_W'(MANT_MAX)};
                        overflow <= 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        acc      <= '0;
                        ovf      <= 1'b0;
                        cnt      <= '0;
                        pend_vld <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_accumulator.sv
// Scoreboard bench for fp_accumulator: expected sums are queued at stimulus time
// and compared (data, overflow, latency, hold stability) when results appear.
module tb_fp_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid, overflow, busy;
    logic [15:0] out_data;

    typedef struct {
        logic [15:0] data;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    logic ov_prev  = 1'b0;

`ifdef NORM_ROUND_EN
    localparam logic [15:0] ROUND_EXP = 16'hC801;
`else
    localparam logic [15:0] ROUND_EXP = 16'hC800;
`endif

    fp_accumulator #(.ACC_W(24), .MAX_TERMS(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [15:0] d, input logic o, input int lat);
        exp_t e;
        e.data = d;
        e.ovf  = o;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting clock.
    task automatic send(input logic [15:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        #1 check("in_ready", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", sb.size(), 0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out", out_valid, 1'b0);
            end else begin
                if (!ov_prev) check("latency", cyc - acc_cyc, sb[0].lat);
                if (out_ready) begin
                    check("out_data", out_data, sb[0].data);
                    check("overflow", overflow, sb[0].ovf);
                    void'(sb.pop_front());
                end else begin
                    check("hold_data", out_data, sb[0].data);
                end
            end
        end
        ov_prev = out_valid;
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 16'h0000);
        check("rst_overflow", overflow, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1'b1);

        // 1.0 + 1.0 at s=3 -> 2.0 at s=7
        send(16'h6008, 1'b0);
        push(16'hE100, 1'b0, 2);
        send(16'h6008, 1'b1);
        drain();

        // 100.0 at s=0 needs trials t=7,6,5
        push(16'hAC80, 1'b0, 4);
        send(16'h0064, 1'b1);
        drain();

        // -1 at s=7
        push(16'hFFFF, 1'b0, 2);
        send(16'hFFFF, 1'b1);
        drain();

        // 16 unterminated beats: term limit ends the sum, result saturates
        for (int i = 0; i < 15; i++) send(16'h0FFF, 1'b0);
        push(16'h0FFF, 1'b1, 9);
        send(16'h0FFF, 1'b0);
        drain();

        // 4097 at s=7 -> halved at t=6, rounding-dependent LSB
        push(ROUND_EXP, 1'b0, 3);
        send(16'hEFFF, 1'b0);
        send(16'hE002, 1'b1);
        drain();

        // clear mid-stream discards the partial sum and blocks the beat
        send(16'h6008, 1'b0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h6008;
        #1 check("clear_in_ready", in_ready, 1'b0);
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        push(16'hFFFF, 1'b0, 2);
        send(16'hFFFF, 1'b1);
        drain();

        // result held stable under back-pressure
        out_ready = 1'b0;
        push(16'hE080, 1'b0, 2);
        send(16'h6008, 1'b1);
        begin
            int n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("stall_valid", out_valid, 1'b1);
        check("stall_busy", busy, 1'b1);
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
        drain();

        // reset while normalising abandons the sum
        send(16'h0064, 1'b1);
        @(negedge clk);
        check("norm_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        repeat (10) @(negedge clk);
        check("post_rst_out_valid", out_valid, 1'b0);

        // sum after reset starts from zero
        push(16'hE100, 1'b0, 2);
        send(16'h6008, 1'b0);
        send(16'h6008, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
